// File: rtl/dispense_sequencer_if.sv
// Handshake bundle between the colour-read/keypad side and the dispense sequencer.
// master: the controlling side (keypad, dispensers); slave: the sequencer.
interface dispense_sequencer_if #(
    parameter int N_CH   = 3,
    parameter int DOSE_W = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     rgb_full;
    logic                     enter;
    logic                     abort;
    logic [N_CH*DOSE_W-1:0]   dose;
    logic [N_CH-1:0]          flags;
    logic [N_CH-1:0]          motores;
    logic                     trigger;
    logic [DOSE_W-1:0]        dose_cur;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic [CH_W-1:0]          err_ch;

    modport master (
        output rgb_full, enter, abort, dose, flags,
        input  motores, trigger, dose_cur, busy, done, error, err_ch
    );

    modport slave (
        input  rgb_full, enter, abort, dose, flags,
        output motores, trigger, dose_cur, busy, done, error, err_ch
    );
endinterface

// File: rtl/dispense_sequencer.sv
// N-channel colourant dispensing sequencer. Arms on a valid colour reading,
// starts on enter, then runs one motor at a time from the highest nonzero
// channel down to channel 0, with a per-channel watchdog, abort and error latch.
module dispense_sequencer #(
    parameter int N_CH        = 3,
    parameter int DOSE_W      = 8,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    dispense_sequencer_if.slave   bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        LOAD  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t                        state;
    logic [CH_W-1:0]               ch;
    logic [TIMEOUT_W-1:0]          timer;
    logic [N_CH-1:0][DOSE_W-1:0]   dose_lat;
    logic [CH_W-1:0]               err_ch_q;

    // Highest channel below 'lim' holding a nonzero dose; MSB flags "found".
    // Searching only below the current channel keeps the index from going under 0.
    function automatic logic [CH_W:0] top_nz(input logic [N_CH-1:0][DOSE_W-1:0] d,
                                             input int lim);
        logic [CH_W:0] r;
        r = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (c < lim && d[c] != '0)
                r = {1'b1, CH_W'(c)};
        end
        return r;
    endfunction

    logic [CH_W:0] nz_start;
    logic [CH_W:0] nz_next;

    // Start channel is taken from the live doses (they are latched on the same edge);
    // the next channel always comes from the latched copy.
    always_comb begin
        nz_start = top_nz(bus.dose, N_CH);
        nz_next  = top_nz(dose_lat, int'(ch));
    end

    // Sequencer state, channel index, watchdog and dose latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ch       <= '0;
            timer    <= '0;
            dose_lat <= '0;
            err_ch_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rgb_full)
                        state <= ARMED;
                end
                ARMED: begin
                    if (!bus.rgb_full) begin
                        state <= IDLE;
                    end else if (bus.enter) begin
                        dose_lat <= bus.dose;
                        timer    <= '0;
                        if (nz_start[CH_W]) begin
                            ch    <= nz_start[CH_W-1:0];
                            state <= LOAD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bus.flags[ch]) begin
                        if (nz_next[CH_W]) begin
                            ch    <= nz_next[CH_W-1:0];
                            state <= GAP;
                        end else begin
                            state <= DONE;
                        end
                    end else if (timer == TMO_LAST) begin
                        err_ch_q <= ch;
                        state    <= ERR;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else begin
                        timer <= '0;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERR: begin
                    if (bus.abort)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore output decode from registered state, channel and latched doses only.
    always_comb begin
        bus.motores  = '0;
        bus.trigger  = 1'b0;
        bus.dose_cur = '0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.error    = 1'b0;
        case (state)
            LOAD: begin
                bus.motores  = N_CH'(1) << ch;
                bus.trigger  = 1'b1;
                bus.dose_cur = dose_lat[ch];
                bus.busy     = 1'b1;
            end
            GAP: begin
                bus.dose_cur = dose_lat[ch];
                bus.busy     = 1'b1;
            end
            DONE:    bus.done  = 1'b1;
            ERR:     bus.error = 1'b1;
            default: ;
        endcase
    end

    assign bus.err_ch = err_ch_q;
endmodule

// File: tb/tb_dispense_sequencer.sv
// Randomised job-level bench for dispense_sequencer. Each job is described by
// its doses, per-channel flag delay and an optional abort point; the expected
// waveform is derived from the channel order (nonzero, descending) and those
// delays, not from any state-machine model.
module tb_dispense_sequencer;
    localparam int N_CH   = 3;
    localparam int DOSE_W = 8;
    localparam int TO     = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dispense_sequencer_if #(.N_CH(N_CH), .DOSE_W(DOSE_W)) bus();

    dispense_sequencer #(
        .N_CH(N_CH), .DOSE_W(DOSE_W), .TIMEOUT_W(16), .TIMEOUT_CYC(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Job description: dose per channel, LOAD cycle (0-based) on which the
    // channel's flag rises (>= TO means never), global LOAD-cycle index of an abort.
    logic [7:0] job_d   [3];
    int         job_dly [3];
    int         job_abort_at;
    bit         job_abort_flag;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_job();
        int  q[$];
        int  lc;
        bit  fin;
        for (int c = N_CH - 1; c >= 0; c--)
            if (job_d[c] != 0) q.push_back(c);
        @(negedge clk);
        bus.rgb_full = 1'b1;
        @(negedge clk);
        chk("armed_busy", bus.busy, 0);
        bus.dose  = {job_d[2], job_d[1], job_d[0]};
        bus.enter = 1'b1;
        @(negedge clk);
        bus.enter = 1'b0;
        bus.dose  = 24'($urandom);  // latched copy must be used from here on
        if (q.size() == 0) begin
            chk("zero_done", bus.done, 1);
            chk("zero_mot", bus.motores, 0);
            @(negedge clk);
            chk("zero_done_clr", bus.done, 0);
            chk("zero_mot2", bus.motores, 0);
        end else begin
            lc  = 0;
            fin = 1'b0;
            for (int i = 0; i < q.size() && !fin; i++) begin
                int c;
                c = q[i];
                for (int k = 0; k < TO && !fin; k++) begin
                    chk("load_mot", bus.motores, 32'(1) << c);
                    chk("load_trig", bus.trigger, 1);
                    chk("load_dose", bus.dose_cur, job_d[c]);
                    chk("load_busy", bus.busy, 1);
                    bus.flags = 3'($urandom) & ~(3'b001 << c);
                    if (lc == job_abort_at) begin
                        bus.abort = 1'b1;
                        if (job_abort_flag) bus.flags[c] = 1'b1;
                        @(negedge clk);
                        bus.abort = 1'b0;
                        bus.flags = '0;
                        chk("abort_mot", bus.motores, 0);
                        chk("abort_trig", bus.trigger, 0);
                        chk("abort_busy", bus.busy, 0);
                        fin = 1'b1;
                    end else if (k == job_dly[c]) begin
                        bus.flags[c] = 1'b1;
                        @(negedge clk);
                        bus.flags = '0;
                        if (i + 1 < q.size()) begin
                            chk("gap_mot", bus.motores, 0);
                            chk("gap_trig", bus.trigger, 0);
                            chk("gap_busy", bus.busy, 1);
                            chk("gap_dose", bus.dose_cur, job_d[q[i+1]]);
                            @(negedge clk);
                        end else begin
                            chk("done_pulse", bus.done, 1);
                            chk("done_mot", bus.motores, 0);
                            chk("done_busy", bus.busy, 0);
                            @(negedge clk);
                            chk("done_clr", bus.done, 0);
                            fin = 1'b1;
                        end
                        break;
                    end else if (k == TO - 1) begin
                        @(negedge clk);
                        bus.flags = '0;
                        chk("err_flag", bus.error, 1);
                        chk("err_ch", bus.err_ch, c);
                        chk("err_mot", bus.motores, 0);
                        chk("err_trig", bus.trigger, 0);
                        bus.enter = 1'b1;
                        repeat (2) @(negedge clk);
                        chk("err_hold", bus.error, 1);
                        chk("err_hold_mot", bus.motores, 0);
                        bus.enter = 1'b0;
                        bus.abort = 1'b1;
                        @(negedge clk);
                        bus.abort = 1'b0;
                        chk("err_clr", bus.error, 0);
                        fin = 1'b1;
                    end else begin
                        @(negedge clk);
                    end
                    lc++;
                end
            end
        end
        bus.rgb_full = 1'b0;
        bus.flags    = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_job(input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0,
                           input int l2, input int l1, input int l0,
                           input int ab, input bit abf);
        job_d[2] = d2; job_d[1] = d1; job_d[0] = d0;
        job_dly[2] = l2; job_dly[1] = l1; job_dly[0] = l0;
        job_abort_at = ab; job_abort_flag = abf;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.rgb_full = 1'b0;
        bus.enter    = 1'b0;
        bus.abort    = 1'b0;
        bus.dose     = '0;
        bus.flags    = '0;
        repeat (2) @(negedge clk);
        chk("rst_mot", bus.motores, 0);
        chk("rst_trig", bus.trigger, 0);
        chk("rst_dose", bus.dose_cur, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.error, 0);
        chk("rst_errch", bus.err_ch, 0);
        reset = 1'b1;
        @(negedge clk);

        // Full three-channel run, single channel, all-zero, timeout on ch2
        set_job(8'd5, 8'd3, 8'd7, 2, 2, 2, -1, 0);   run_job();
        set_job(8'd0, 8'd4, 8'd0, 99, 2, 99, -1, 0); run_job();
        set_job(8'd0, 8'd0, 8'd0, 0, 0, 0, -1, 0);   run_job();
        set_job(8'd9, 8'd1, 8'd1, 99, 1, 1, -1, 0);  run_job();
        // Abort together with flags[1]; flag on the very timeout cycle
        set_job(8'd5, 8'd6, 8'd7, 1, 5, 1, 3, 1);    run_job();
        set_job(8'd5, 8'd6, 8'd7, TO-1, TO-1, 0, -1, 0); run_job();

        // rgb_full dropping in ARMED prevents a later start
        @(negedge clk);
        bus.rgb_full = 1'b1;
        @(negedge clk);
        bus.rgb_full = 1'b0;
        @(negedge clk);
        bus.dose  = {8'd1, 8'd2, 8'd3};
        bus.enter = 1'b1;
        repeat (2) @(negedge clk);
        chk("drop_mot", bus.motores, 0);
        chk("drop_busy", bus.busy, 0);
        bus.enter = 1'b0;
        @(negedge clk);

        // Asynchronous reset while loading channel 1
        bus.rgb_full = 1'b1;
        @(negedge clk);
        bus.dose  = {8'd0, 8'd5, 8'd0};
        bus.enter = 1'b1;
        @(negedge clk);
        bus.enter = 1'b0;
        chk("prerst_mot", bus.motores, 3'b010);
        reset = 1'b0;
        #1;
        chk("arst_mot", bus.motores, 0);
        chk("arst_trig", bus.trigger, 0);
        chk("arst_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.rgb_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);

        // Randomised jobs
        for (int j = 0; j < 60; j++) begin
            for (int c = 0; c < N_CH; c++) begin
                job_d[c]   = ($urandom_range(0, 9) < 3) ? 8'd0 : 8'($urandom_range(1, 255));
                job_dly[c] = $urandom_range(0, TO + 1);
            end
            job_abort_at   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 12) : -1;
            job_abort_flag = 1'($urandom);
            run_job();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
